lcd_cmd_seq: RTL

//  Host-side command sequencer driving the LCD controller's cmd/cmd_valid port.

---
 rtl/lcd_cmd_seq.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/lcd_cmd_seq.sv
// ----------------------------------------------------------------------------
// lcd_cmd_seq
//
// Host-side command sequencer for the LCD controller. Image-op commands from a
// script source or CPU are buffered in a small FIFO. They are issued one at a
// time on the controller's cmd/cmd_valid port, and only while the controller
// reports idle. Each issue is tracked through the controller's busy handshake.
//
// A write-out command (0) is tracked by the done pulse instead of busy. Once
// done arrives, the sequencer parks in a terminal state until reset.
//
// Parameters
//   DEPTH   command FIFO entries (power of 2, >= 2)
//   ACK_TO  cycles to wait for busy to rise after an issue before flagging err
//
// Ports
//   clk         system clock, all logic on posedge
//   reset_n     asynchronous active-low reset
//   in_cmd      command to enqueue (0 = write-out, 1..12 = image ops)
//   in_valid    push request
//   in_ready    push accepted when in_valid & in_ready
//   cmd         command presented to the LCD controller
//   cmd_valid   one-cycle command strobe
//   busy        LCD controller busy
//   done        LCD controller write-out complete
//   seq_done    sticky, the write-out command finished
//   err         sticky, an illegal command was pushed or busy never rose
//   issued_cnt  commands issued, saturates at 255
//   level       FIFO occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module lcd_cmd_seq #(
    parameter int DEPTH  = 8,
    parameter int ACK_TO = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [3:0]               in_cmd,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [3:0]               cmd,
    output logic                     cmd_valid,
    input  logic                     busy,
    input  logic                     done,
    output logic                     seq_done,
    output logic                     err,
    output logic [7:0]               issued_cnt,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;

    localparam logic [TW-1:0] TMR_LAST  = TW'(ACK_TO - 1);
    localparam logic [AW:0]   LVL_FULL  = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   LVL_ONE   = (AW + 1)'(1);
    localparam logic [3:0]    CMD_WROUT = 4'h0;
    localparam logic [3:0]    CMD_BAD   = 4'hD;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_HI,
        WAIT_LO,
        WAIT_DONE,
        FINISH
    } state_t;

    // Counter that sticks at its maximum instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Commands 0xD..0xF have no meaning to the controller.
    function automatic logic cmd_legal(input logic [3:0] c);
        return c < CMD_BAD;
    endfunction

    state_t        state;
    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [TW-1:0] ack_tmr;

    logic fifo_full;
    logic fifo_empty;
    logic push_acc;
    logic push_store;
    logic push_bad;
    logic pop;
    logic ack_timeout;

    assign fifo_full  = (level == LVL_FULL);
    assign fifo_empty = (level == '0);

    // Ready comes from registered state only. A full FIFO refuses a push even
    // in the cycle where the head is being popped.
    assign in_ready   = !fifo_full && (state != FINISH);

    // An illegal command is consumed so the source does not stall on it. It is
    // then dropped, and only the sticky error records it.
    assign push_acc   = in_valid && in_ready;
    assign push_store = push_acc && cmd_legal(in_cmd);
    assign push_bad   = push_acc && !cmd_legal(in_cmd);

    // The head can only be popped from IDLE with busy low. Level is
    // registered, so an entry pushed into an empty FIFO becomes issuable one
    // cycle later at the earliest.
    assign pop         = (state == IDLE) && !fifo_empty && !busy;
    assign ack_timeout = (state == WAIT_HI) && !busy && (ack_tmr == TMR_LAST);

    // Storage is not reset. Entries are valid only between the read and write
    // pointers, and resetting the pointers discards everything queued.
    always_ff @(posedge clk) begin
        if (push_store) begin
            mem[wr_ptr] <= in_cmd;
        end
    end

    // FIFO pointers and occupancy. Pointers wrap naturally since DEPTH is a
    // power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_store) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_store, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    // Issue FSM. At most one command is outstanding at any time. The shortest
    // loop IDLE -> ISSUE -> WAIT_HI -> WAIT_LO -> IDLE gives a minimum spacing
    // of four cycles between strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cmd        <= '0;
            cmd_valid  <= 1'b0;
            seq_done   <= 1'b0;
            err        <= 1'b0;
            issued_cnt <= '0;
            ack_tmr    <= '0;
        end else begin
            if (push_bad || ack_timeout) begin
                err <= 1'b1;
            end

            case (state)
                // A controller still busy after reset is simply waited out here.
                IDLE: begin
                    if (pop) begin
                        cmd        <= mem[rd_ptr];
                        cmd_valid  <= 1'b1;
                        issued_cnt <= sat_inc8(issued_cnt);
                        state      <= ISSUE;
                    end
                end

                // The strobe lasts exactly one cycle, and cmd keeps its value
                // after the strobe. A write-out is acknowledged by done,
                // everything else by a busy pulse.
                ISSUE: begin
                    cmd_valid <= 1'b0;
                    ack_tmr   <= '0;
                    state     <= (cmd == CMD_WROUT) ? WAIT_DONE : WAIT_HI;
                end

                WAIT_HI: begin
                    if (busy) begin
                        state <= WAIT_LO;
                    end else if (ack_timeout) begin
                        state <= IDLE;
                    end else begin
                        ack_tmr <= ack_tmr + TW'(1);
                    end
                end

                WAIT_LO: begin
                    if (!busy) begin
                        state <= IDLE;
                    end
                end

                // Write-out has no timeout. The controller may take arbitrarily long.
                WAIT_DONE: begin
                    if (done) begin
                        seq_done <= 1'b1;
                        state    <= FINISH;
                    end
                end

                // Terminal state. Anything still queued is never issued.
                FINISH: begin
                    state <= FINISH;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
